// File: rtl/writeback_regfile.sv
// Writeback select, 32x32 register file with two async read ports, retire counter.
// Optional same-cycle write-through bypass on reads: define WB_BYPASS_EN.
module writeback_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write_in,
  input  logic [1:0]      mem_reg_in,
  input  logic [XLEN-1:0] alu_res_in,
  input  logic [XLEN-1:0] wrap_load_in,
  input  logic [XLEN-1:0] next_sel_addr_in,
  input  logic [XLEN-1:0] pre_address_in,
  input  logic [31:0]     instruction_in,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_en_out,
  output logic [4:0]      wb_rd_out,
  output logic [XLEN-1:0] wb_data_out,
  output logic [63:0]     instret_out
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [63:0]     instret_q;
  logic [63:0]     instret_d;
  logic [4:0]      rd;
  logic            retire;

  assign rd        = instruction_in[11:7];
  assign retire    = (instruction_in != 32'd0);
  assign wb_rd_out = rd;
  assign wb_en_out = reg_write_in && (rd != 5'd0);

  always_comb begin
    wb_data_out = alu_res_in;
    unique case (mem_reg_in)
      2'b00: wb_data_out = alu_res_in;
      2'b01: wb_data_out = wrap_load_in;
      2'b10: wb_data_out = next_sel_addr_in;
      2'b11: wb_data_out = pre_address_in;
      default: wb_data_out = alu_res_in;
    endcase
  end

  function automatic logic [XLEN-1:0] rd_port(
    input logic [4:0] a
  );
    logic [XLEN-1:0] v;
    v = regs_q[a];
`ifdef WB_BYPASS_EN
    if (wb_en_out && (a == rd))
      v = wb_data_out;
`endif
    // x0 wins over everything, bypass included
    if (a == 5'd0)
      v = '0;
    return v;
  endfunction

  assign rs1_data = rd_port(rs1_addr);
  assign rs2_data = rd_port(rs2_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++)
        if (wb_en_out && (rd == 5'(i)))
          regs_q[i] <= wb_data_out;
    end
  end

  assign instret_d = retire ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      instret_q <= '0;
    else
      instret_q <= instret_d;
  end

  assign instret_out = instret_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: vector table, scoreboard queue,
// and hand-written reset, hazard, retire and wrap sequences.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_in;
  logic [1:0]  mem_reg_in;
  logic [31:0] alu_res_in;
  logic [31:0] wrap_load_in;
  logic [31:0] next_sel_addr_in;
  logic [31:0] pre_address_in;
  logic [31:0] instruction_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_en_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;
  logic [63:0] instret_out;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_regfile dut (
    .clk              (clk),
    .rst              (rst),
    .reg_write_in     (reg_write_in),
    .mem_reg_in       (mem_reg_in),
    .alu_res_in       (alu_res_in),
    .wrap_load_in     (wrap_load_in),
    .next_sel_addr_in (next_sel_addr_in),
    .pre_address_in   (pre_address_in),
    .instruction_in   (instruction_in),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .wb_en_out        (wb_en_out),
    .wb_rd_out        (wb_rd_out),
    .wb_data_out      (wb_data_out),
    .instret_out      (instret_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] nxt;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        exp_en;
    logic [31:0] exp_wb;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ins(input logic [4:0] r);
    return {20'h00000, r, 7'h33};
  endfunction

  task automatic drive(input logic rw, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] nxt, input logic [31:0] pc,
                       input logic [31:0] ins);
    reg_write_in     = rw;
    mem_reg_in       = sel;
    alu_res_in       = alu;
    wrap_load_in     = ld;
    next_sel_addr_in = nxt;
    pre_address_in   = pc;
    instruction_in   = ins;
  endtask

  task automatic bubble();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [31:0] hz_exp;

    vecs[0] = '{1'b1, 2'b01, 32'h0BAD0001, 32'hDEADBEEF, 32'h0BAD0002,
                32'h0BAD0003, 5'd7, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 2'b00, 32'h11111111, 32'h0BAD0004, 32'h0BAD0005,
                32'h0BAD0006, 5'd3, 1'b1, 32'h11111111, 32'h11111111};
    vecs[2] = '{1'b1, 2'b10, 32'h0BAD0007, 32'h0BAD0008, 32'h22222222,
                32'h0BAD0009, 5'd4, 1'b1, 32'h22222222, 32'h22222222};
    vecs[3] = '{1'b1, 2'b11, 32'h0BAD000A, 32'h0BAD000B, 32'h0BAD000C,
                32'h33333333, 5'd5, 1'b1, 32'h33333333, 32'h33333333};
    vecs[4] = '{1'b1, 2'b00, 32'h12345678, 32'h0, 32'h0,
                32'h0, 5'd0, 1'b0, 32'h12345678, 32'h00000000};
    vecs[5] = '{1'b0, 2'b00, 32'h44444444, 32'h0, 32'h0,
                32'h0, 5'd6, 1'b0, 32'h44444444, 32'h00000000};

    rst = 1'b0;
    bubble();
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    chk("reset_instret", instret_out, 64'd0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      #0.1;
      chk($sformatf("reset_read_x%0d", a), {32'd0, rs1_data}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(vecs[i].rw, vecs[i].sel, vecs[i].alu, vecs[i].ld,
            vecs[i].nxt, vecs[i].pc, mk_ins(vecs[i].rd));
      rs1_addr = 5'd0;
      #1;
      chk($sformatf("v%0d_wb_en", i), {63'd0, wb_en_out},
          {63'd0, vecs[i].exp_en});
      chk($sformatf("v%0d_wb_data", i), {32'd0, wb_data_out},
          {32'd0, vecs[i].exp_wb});
      chk($sformatf("v%0d_wb_rd", i), {59'd0, wb_rd_out},
          {59'd0, vecs[i].rd});
      chk($sformatf("v%0d_x0_now", i), {32'd0, rs1_data}, 64'd0);
      sb.push_back('{vecs[i].rd, vecs[i].exp_rd});
      @(posedge clk);
      #1;
      reg_write_in = 1'b0;
      e = sb.pop_front();
      rs1_addr = e.addr;
      rs2_addr = e.addr;
      #1;
      chk($sformatf("v%0d_rs1_after", i), {32'd0, rs1_data},
          {32'd0, e.data});
      chk($sformatf("v%0d_rs2_after", i), {32'd0, rs2_data},
          {32'd0, e.data});
    end
    chk("v_instret", instret_out, 64'd6);

    @(negedge clk);
    drive(1'b1, 2'b00, 32'hCAFEF00D, 32'd0, 32'd0, 32'd0, mk_ins(5'd5));
    #2;
    rst = 1'b0;
    #1;
    chk("pulse_instret", instret_out, 64'd0);
    rs1_addr = 5'd5;
    #1;
    chk("pulse_x5_now", {32'd0, rs1_data}, 64'd0);
    chk("pulse_wb_en_in_reset", {63'd0, wb_en_out}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bubble();
    #1;
    chk("pulse_x5_after", {32'd0, rs1_data}, 64'd0);
    chk("pulse_instret_after", instret_out, 64'd0);

    @(negedge clk);
    drive(1'b1, 2'b00, 32'd1, 32'd0, 32'd0, 32'd0, mk_ins(5'd1));
    @(negedge clk);
    bubble();
    @(negedge clk);
    drive(1'b1, 2'b01, 32'd0, 32'd2, 32'd0, 32'd0, mk_ins(5'd2));
    @(negedge clk);
    bubble();
    @(negedge clk);
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'h00112023);
    @(negedge clk);
    drive(1'b1, 2'b10, 32'd0, 32'd0, 32'd3, 32'd0, mk_ins(5'd8));
    #1;
    chk("retire_lag", instret_out, 64'd3);
    @(posedge clk);
    #1;
    chk("retire_count", instret_out, 64'd4);

    @(negedge clk);
    drive(1'b1, 2'b00, 32'h00000001, 32'd0, 32'd0, 32'd0, mk_ins(5'd9));
    @(negedge clk);
    drive(1'b1, 2'b00, 32'hA5A5A5A5, 32'd0, 32'd0, 32'd0, mk_ins(5'd9));
    rs1_addr = 5'd9;
    rs2_addr = 5'd9;
    #1;
`ifdef WB_BYPASS_EN
    hz_exp = 32'hA5A5A5A5;
`else
    hz_exp = 32'h00000001;
`endif
    chk("hazard_rs1_same", {32'd0, rs1_data}, {32'd0, hz_exp});
    chk("hazard_rs2_same", {32'd0, rs2_data}, {32'd0, hz_exp});
    @(negedge clk);
    bubble();
    #1;
    chk("hazard_rs1_next", {32'd0, rs1_data}, 64'h00000000A5A5A5A5);
    chk("hazard_rs2_next", {32'd0, rs2_data}, 64'h00000000A5A5A5A5);

    @(negedge clk);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 32'h00112023);
    #1;
    chk("wrap_pre", instret_out, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    chk("wrap_zero", instret_out, 64'd0);
    @(negedge clk);
    bubble();
    @(posedge clk);
    #1;
    chk("wrap_hold", instret_out, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
